// File: rtl/axi_chan_reg_slice.sv
// Valid/ready register slice with selectable PASS/FWD/REV/FULL handshake registering.
// Define AXI_RS_PAYLOAD_RST_EN to clear payload storage on reset.
module axi_chan_reg_slice #(
    parameter int unsigned HNDSHK_MODE = 3,
    parameter int unsigned PAYLD_WIDTH = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   valid_src,
    input  logic [PAYLD_WIDTH-1:0] payload_src,
    output logic                   ready_src,
    output logic                   valid_dst,
    output logic [PAYLD_WIDTH-1:0] payload_dst,
    input  logic                   ready_dst
);

    if (PAYLD_WIDTH < 1) begin : g_bad_width
        $error("axi_chan_reg_slice: PAYLD_WIDTH must be >= 1");
    end

    case (HNDSHK_MODE)
        0: begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, aclk, aresetn};
            assign ready_src      = ready_dst;
            assign valid_dst      = valid_src;
            assign payload_dst    = payload_src;
        end

        1: begin : g_fwd
            logic                   valid_q;
            logic [PAYLD_WIDTH-1:0] data_q;

            assign ready_src   = ready_dst || !valid_q;
            assign valid_dst   = valid_q;
            assign payload_dst = data_q;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    valid_q <= 1'b0;
                end else if (ready_src) begin
                    valid_q <= valid_src;
                end
            end

            always_ff @(posedge aclk) begin
`ifdef AXI_RS_PAYLOAD_RST_EN
                if (!aresetn) data_q <= '0; else
`endif
                if (valid_src && ready_src) data_q <= payload_src;
            end
        end

        2: begin : g_rev
            logic                   skid_valid_q;
            logic                   skid_valid_d;
            logic                   ready_q;
            logic                   push;
            logic [PAYLD_WIDTH-1:0] skid_q;

            assign push        = valid_src && ready_q;
            assign ready_src   = ready_q;
            // src valid is gated by ready_q so nothing leaks through while reset holds ready low
            assign valid_dst   = skid_valid_q || (valid_src && ready_q);
            assign payload_dst = skid_valid_q ? skid_q : payload_src;

            always_comb begin
                skid_valid_d = skid_valid_q;
                if (skid_valid_q) begin
                    skid_valid_d = !ready_dst;
                end else if (push && !ready_dst) begin
                    skid_valid_d = 1'b1;
                end
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                end else begin
                    skid_valid_q <= skid_valid_d;
                    ready_q      <= !skid_valid_d;
                end
            end

            always_ff @(posedge aclk) begin
`ifdef AXI_RS_PAYLOAD_RST_EN
                if (!aresetn) skid_q <= '0; else
`endif
                if (!skid_valid_q && push && !ready_dst) skid_q <= payload_src;
            end
        end

        3: begin : g_full
            typedef enum logic [1:0] {
                OCC_0,
                OCC_1,
                OCC_2
            } occ_t;

            occ_t                   occ_q;
            occ_t                   occ_d;
            logic                   valid_q;
            logic                   ready_q;
            logic                   push;
            logic                   pop;
            logic [PAYLD_WIDTH-1:0] head_q;
            logic [PAYLD_WIDTH-1:0] head_d;
            logic [PAYLD_WIDTH-1:0] tail_q;
            logic [PAYLD_WIDTH-1:0] tail_d;

            assign push        = valid_src && ready_q;
            assign pop         = valid_q && ready_dst;
            assign ready_src   = ready_q;
            assign valid_dst   = valid_q;
            assign payload_dst = head_q;

            always_comb begin
                occ_d  = occ_q;
                head_d = head_q;
                tail_d = tail_q;
                case (occ_q)
                    OCC_0: begin
                        if (push) begin
                            occ_d  = OCC_1;
                            head_d = payload_src;
                        end
                    end
                    OCC_1: begin
                        // push+pop at one entry replaces head in place, occupancy unchanged
                        if (push && pop) begin
                            head_d = payload_src;
                        end else if (push) begin
                            occ_d  = OCC_2;
                            tail_d = payload_src;
                        end else if (pop) begin
                            occ_d = OCC_0;
                        end
                    end
                    OCC_2: begin
                        if (pop) begin
                            occ_d  = OCC_1;
                            head_d = tail_q;
                        end
                    end
                    default: occ_d = OCC_0;
                endcase
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    occ_q   <= OCC_0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b0;
                end else begin
                    occ_q   <= occ_d;
                    valid_q <= (occ_d != OCC_0);
                    ready_q <= (occ_d != OCC_2);
                end
            end

            always_ff @(posedge aclk) begin
`ifdef AXI_RS_PAYLOAD_RST_EN
                if (!aresetn) begin
                    head_q <= '0;
                    tail_q <= '0;
                end else
`endif
                begin
                    head_q <= head_d;
                    tail_q <= tail_d;
                end
            end
        end

        default: begin : g_bad_mode
            $error("axi_chan_reg_slice: HNDSHK_MODE must be 0..3");
        end
    endcase

endmodule

// File: tb/tb_axi_chan_reg_slice.sv
// Directed bench for axi_chan_reg_slice: one instance per handshake mode, all 8-bit payload.
module tb_axi_chan_reg_slice;

    logic       aclk = 1'b0;
    logic       aresetn;

    logic       f_vs, f_rs, f_vd, f_rd;
    logic [7:0] f_ps, f_pd;
    logic       w_vs, w_rs, w_vd, w_rd;
    logic [7:0] w_ps, w_pd;
    logic       r_vs, r_rs, r_vd, r_rd;
    logic [7:0] r_ps, r_pd;
    logic       p_vs, p_rs, p_vd, p_rd;
    logic [7:0] p_ps, p_pd;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 aclk = ~aclk;

    axi_chan_reg_slice #(.HNDSHK_MODE(3), .PAYLD_WIDTH(8)) u_full (
        .aclk(aclk), .aresetn(aresetn),
        .valid_src(f_vs), .payload_src(f_ps), .ready_src(f_rs),
        .valid_dst(f_vd), .payload_dst(f_pd), .ready_dst(f_rd)
    );

    axi_chan_reg_slice #(.HNDSHK_MODE(1), .PAYLD_WIDTH(8)) u_fwd (
        .aclk(aclk), .aresetn(aresetn),
        .valid_src(w_vs), .payload_src(w_ps), .ready_src(w_rs),
        .valid_dst(w_vd), .payload_dst(w_pd), .ready_dst(w_rd)
    );

    axi_chan_reg_slice #(.HNDSHK_MODE(2), .PAYLD_WIDTH(8)) u_rev (
        .aclk(aclk), .aresetn(aresetn),
        .valid_src(r_vs), .payload_src(r_ps), .ready_src(r_rs),
        .valid_dst(r_vd), .payload_dst(r_pd), .ready_dst(r_rd)
    );

    axi_chan_reg_slice #(.HNDSHK_MODE(0), .PAYLD_WIDTH(8)) u_pass (
        .aclk(aclk), .aresetn(aresetn),
        .valid_src(p_vs), .payload_src(p_ps), .ready_src(p_rs),
        .valid_dst(p_vd), .payload_dst(p_pd), .ready_dst(p_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        {f_vs, f_rd, w_vs, w_rd, r_vs, r_rd, p_vs, p_rd} = '0;
        {f_ps, w_ps, r_ps, p_ps} = '0;

        // reset held for three edges
        repeat (3) tick();
        chk("rst_full_vd", 32'(f_vd), 32'd0);
        chk("rst_full_rs", 32'(f_rs), 32'd0);
        chk("rst_rev_rs",  32'(r_rs), 32'd0);
        chk("rst_fwd_vd",  32'(w_vd), 32'd0);
`ifdef AXI_RS_PAYLOAD_RST_EN
        chk("rst_full_pd", 32'(f_pd), 32'd0);
`endif
        aresetn = 1'b1;
        tick();
        chk("rel_full_rs", 32'(f_rs), 32'd1);
        chk("rel_full_vd", 32'(f_vd), 32'd0);
        chk("rel_rev_rs",  32'(r_rs), 32'd1);

        // FULL streaming, ready_dst high
        f_rd = 1'b1; f_vs = 1'b1; f_ps = 8'h11;
        tick();
        chk("str_vd0", 32'(f_vd), 32'd1);
        chk("str_pd0", 32'(f_pd), 32'h11);
        f_ps = 8'h22;
        tick();
        chk("str_pd1", 32'(f_pd), 32'h22);
        f_ps = 8'h33;
        tick();
        chk("str_pd2", 32'(f_pd), 32'h33);
        chk("str_rs2", 32'(f_rs), 32'd1);
        f_vs = 1'b0;
        tick();
        chk("str_drain_vd", 32'(f_vd), 32'd0);

        // FULL backpressure fills both entries
        f_rd = 1'b0; f_vs = 1'b1; f_ps = 8'hA1;
        tick();
        chk("bp_rs1", 32'(f_rs), 32'd1);
        chk("bp_pd1", 32'(f_pd), 32'hA1);
        f_ps = 8'hA2;
        tick();
        chk("bp_rs2", 32'(f_rs), 32'd0);
        chk("bp_pd2", 32'(f_pd), 32'hA1);
        f_ps = 8'hA3;
        tick();
        chk("bp_hold_rs", 32'(f_rs), 32'd0);
        chk("bp_hold_vd", 32'(f_vd), 32'd1);
        chk("bp_hold_pd", 32'(f_pd), 32'hA1);
        f_rd = 1'b1;
        tick();
        chk("bp_pop_pd", 32'(f_pd), 32'hA2);
        chk("bp_pop_rs", 32'(f_rs), 32'd1);
        tick();
        chk("bp_a3_pd", 32'(f_pd), 32'hA3);
        f_vs = 1'b0;
        tick();
        chk("bp_empty_vd", 32'(f_vd), 32'd0);

        // FULL push and pop together at occupancy 1
        f_vs = 1'b1; f_ps = 8'h05;
        tick();
        chk("pp_pd5", 32'(f_pd), 32'h05);
        f_ps = 8'h06;
        tick();
        chk("pp_pd6", 32'(f_pd), 32'h06);
        chk("pp_vd",  32'(f_vd), 32'd1);
        chk("pp_rs",  32'(f_rs), 32'd1);
        f_vs = 1'b0;
        tick();
        chk("pp_empty_vd", 32'(f_vd), 32'd0);

        // FULL reset while holding two beats
        f_rd = 1'b0; f_vs = 1'b1; f_ps = 8'hC1;
        tick();
        f_ps = 8'hC2;
        tick();
        chk("mr_full_rs", 32'(f_rs), 32'd0);
        f_vs = 1'b0; aresetn = 1'b0;
        tick();
        chk("mr_rst_vd", 32'(f_vd), 32'd0);
        chk("mr_rst_rs", 32'(f_rs), 32'd0);
        aresetn = 1'b1; f_rd = 1'b1;
        tick();
        chk("mr_rel_rs", 32'(f_rs), 32'd1);
        chk("mr_rel_vd", 32'(f_vd), 32'd0);
        tick();
        chk("mr_nostale_vd", 32'(f_vd), 32'd0);

        // REV: zero latency, skid captures the unaccepted beat
        r_rd = 1'b0; r_vs = 1'b1; r_ps = 8'h7E;
        settle();
        chk("rev_vd_same", 32'(r_vd), 32'd1);
        chk("rev_pd_same", 32'(r_pd), 32'h7E);
        tick();
        r_vs = 1'b0; r_ps = 8'h00;
        settle();
        chk("rev_skid_rs", 32'(r_rs), 32'd0);
        chk("rev_skid_vd", 32'(r_vd), 32'd1);
        chk("rev_skid_pd", 32'(r_pd), 32'h7E);
        r_rd = 1'b1;
        tick();
        chk("rev_pop_rs", 32'(r_rs), 32'd1);
        chk("rev_pop_vd", 32'(r_vd), 32'd0);
        r_vs = 1'b1; r_ps = 8'h5A;
        settle();
        chk("rev_thru_pd", 32'(r_pd), 32'h5A);
        tick();
        chk("rev_thru_rs", 32'(r_rs), 32'd1);
        r_vs = 1'b0;

        // FWD: valid appears one edge after the push
        w_rd = 1'b1; w_vs = 1'b1; w_ps = 8'h7E;
        settle();
        chk("fwd_vd_pre", 32'(w_vd), 32'd0);
        chk("fwd_rs_pre", 32'(w_rs), 32'd1);
        tick();
        w_vs = 1'b0; w_rd = 1'b0;
        settle();
        chk("fwd_vd_post", 32'(w_vd), 32'd1);
        chk("fwd_pd_post", 32'(w_pd), 32'h7E);
        chk("fwd_rs_bp",   32'(w_rs), 32'd0);
        tick();
        chk("fwd_hold_pd", 32'(w_pd), 32'h7E);
        w_rd = 1'b1;
        tick();
        chk("fwd_pop_vd", 32'(w_vd), 32'd0);

        // PASS: pure wires
        p_vs = 1'b1; p_ps = 8'h3C; p_rd = 1'b0;
        settle();
        chk("pass_vd", 32'(p_vd), 32'd1);
        chk("pass_pd", 32'(p_pd), 32'h3C);
        chk("pass_rs0", 32'(p_rs), 32'd0);
        p_rd = 1'b1;
        settle();
        chk("pass_rs1", 32'(p_rs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
